// File: rtl/serial_link_pkg.sv
// Constants and types shared by the serial link transmitter and receiver.
package serial_link_pkg;

  localparam int SL_BYTE_W = 8;
  localparam logic [SL_BYTE_W-1:0] SL_SYNC_PATTERN = 8'h55;

  typedef enum logic {HUNT, RECV} rx_state_t;

  // The hunt counter must be able to hold byte_w itself, not just byte_w-1.
  function automatic int hunt_cnt_w(input int byte_w);
    return $clog2(byte_w + 1);
  endfunction

endpackage

// File: rtl/rx_bit_shifter.sv
// LSB-first shift register with bit counter; byte_done strobes combinationally on the last bit's edge.
// No backpressure: shifts whenever shift_en is high.
module rx_bit_shifter #(
  parameter int BYTE_W = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              count_en,
  input  logic              count_clr,
  output logic [BYTE_W-1:0] sr_next,
  output logic              byte_done
);

  localparam int BIT_CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(BYTE_W - 1);

  logic [BYTE_W-1:0] sr;
  logic [BIT_CW-1:0] bit_cnt;

  assign sr_next   = {bit_in, sr[BYTE_W-1:1]};
  assign byte_done = shift_en && count_en && (bit_cnt == LAST_BIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) begin
        sr <= sr_next;
      end
      if (count_clr) begin
        bit_cnt <= '0;
      end else if (shift_en && count_en) begin
        bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_byte_receiver.sv
// Hunts for a sync byte, then delivers FRAME_LEN bytes on a valid/ready register; a byte arriving
// while the register is still held is dropped and flagged in sticky OVERRUN.
module serial_byte_receiver
  import serial_link_pkg::*;
#(
  parameter int                BYTE_W       = SL_BYTE_W,
  parameter logic [BYTE_W-1:0] SYNC_PATTERN = BYTE_W'(SL_SYNC_PATTERN),
  parameter int                FRAME_LEN    = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              BIT_IN,
  input  logic              BIT_VALID,
  output logic [BYTE_W-1:0] BYTE_OUT,
  output logic              BYTE_VALID,
  input  logic              BYTE_READY,
  output logic              SYNCED,
  output logic              FRAME_DONE,
  output logic              OVERRUN,
  input  logic              OVR_CLR
);

  localparam int HUNT_CW = hunt_cnt_w(BYTE_W);
  localparam int BYTE_CW = $clog2(FRAME_LEN + 1);
  localparam logic [HUNT_CW-1:0] HUNT_FULL  = HUNT_CW'(BYTE_W);
  localparam logic [BYTE_CW-1:0] FRAME_LAST = BYTE_CW'(FRAME_LEN);

  rx_state_t state, state_nxt;

  logic [HUNT_CW-1:0] hunt_cnt, hunt_cnt_inc;
  logic [BYTE_CW-1:0] byte_cnt, byte_cnt_inc;
  logic [BYTE_W-1:0]  sr_next;
  logic               byte_done;
  logic               sync_match;
  logic               frame_end;
  logic               out_free;
  logic               drop;

  rx_bit_shifter #(
    .BYTE_W(BYTE_W)
  ) u_shifter (
    .CLK      (CLK),
    .nRST     (nRST),
    .shift_en (BIT_VALID),
    .bit_in   (BIT_IN),
    .count_en (state == RECV),
    .count_clr(sync_match),
    .sr_next  (sr_next),
    .byte_done(byte_done)
  );

  // Saturation means the shifter holds only bits received since hunting began.
  assign hunt_cnt_inc = (hunt_cnt == HUNT_FULL) ? hunt_cnt : hunt_cnt + 1'b1;
  assign byte_cnt_inc = byte_cnt + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sync_match = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      HUNT: begin
        if (BIT_VALID && (hunt_cnt_inc == HUNT_FULL) && (sr_next == SYNC_PATTERN)) begin
          sync_match = 1'b1;
          state_nxt  = RECV;
        end
      end
      RECV: begin
        if (byte_done && (byte_cnt_inc == FRAME_LAST)) begin
          frame_end = 1'b1;
          state_nxt = HUNT;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hunt_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      if (frame_end) begin
        hunt_cnt <= '0;
      end else if ((state == HUNT) && BIT_VALID) begin
        hunt_cnt <= hunt_cnt_inc;
      end
      if (sync_match) begin
        byte_cnt <= '0;
      end else if (byte_done) begin
        byte_cnt <= byte_cnt_inc;
      end
    end
  end

  assign out_free = !BYTE_VALID || BYTE_READY;
  assign drop     = byte_done && !out_free;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      BYTE_OUT   <= '0;
      BYTE_VALID <= 1'b0;
      FRAME_DONE <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (byte_done && out_free) begin
        BYTE_OUT   <= sr_next;
        BYTE_VALID <= 1'b1;
      end else if (BYTE_READY) begin
        BYTE_VALID <= 1'b0;
      end
      FRAME_DONE <= frame_end;
      if (drop) begin
        OVERRUN <= 1'b1;
      end else if (OVR_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  assign SYNCED = (state == RECV);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: vector table, directed corner sequences, then random traffic
// compared against a bit-queue reference model.
module tb_serial_byte_receiver;

  localparam int BW = 8;
  localparam int FL = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          BIT_IN = 1'b0;
  logic          BIT_VALID = 1'b0;
  logic          BYTE_READY = 1'b0;
  logic          OVR_CLR = 1'b0;
  logic [BW-1:0] BYTE_OUT;
  logic          BYTE_VALID;
  logic          SYNCED;
  logic          FRAME_DONE;
  logic          OVERRUN;

  int checks = 0;
  int errors = 0;
  int vld_seen = 0;
  int sync_seen = 0;
  bit model_on = 1'b0;

  logic [7:0] sync_pat = 8'h55;

  // Reference model state: bit queues rather than counters.
  bit         m_hunting;
  bit         hist[$];
  bit         cur[$];
  int         m_nbytes;
  logic [7:0] m_out;
  bit         m_valid;
  bit         m_ovr;
  bit         m_done;

  typedef struct {
    logic [7:0] pre;
    int         pre_len;
    logic [7:0] data;
    int         exp_sync;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[5];

  always #5 CLK = ~CLK;

  serial_byte_receiver #(
    .BYTE_W      (BW),
    .SYNC_PATTERN(8'h55),
    .FRAME_LEN   (FL)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .BIT_IN    (BIT_IN),
    .BIT_VALID (BIT_VALID),
    .BYTE_OUT  (BYTE_OUT),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY),
    .SYNCED    (SYNCED),
    .FRAME_DONE(FRAME_DONE),
    .OVERRUN   (OVERRUN),
    .OVR_CLR   (OVR_CLR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pack_bits(input bit q[$]);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_hunting = 1'b1;
    hist.delete();
    cur.delete();
    m_nbytes = 0;
    m_out = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit bv, input bit bi, input bit rdy, input bit clr);
    bit         newb;
    bit         drop;
    logic [7:0] b;
    newb = 1'b0;
    drop = 1'b0;
    b = '0;
    m_done = 1'b0;
    if (bv) begin
      if (m_hunting) begin
        hist.push_back(bi);
        if (hist.size() > 8) void'(hist.pop_front());
        if (hist.size() == 8 && pack_bits(hist) == sync_pat) begin
          m_hunting = 1'b0;
          cur.delete();
          m_nbytes = 0;
        end
      end else begin
        cur.push_back(bi);
        if (cur.size() == 8) begin
          b = pack_bits(cur);
          cur.delete();
          m_nbytes++;
          newb = 1'b1;
          if (m_nbytes == FL) begin
            m_hunting = 1'b1;
            hist.delete();
            m_done = 1'b1;
          end
        end
      end
    end
    if (newb) begin
      if (!m_valid || rdy) begin
        m_out = b;
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (model_on) model_step(BIT_VALID, BIT_IN, BYTE_READY, OVR_CLR);
    #1;
    if (BYTE_VALID) vld_seen++;
    if (SYNCED) sync_seen++;
    if (model_on) begin
      chk("rnd_byte_valid", BYTE_VALID, m_valid);
      chk("rnd_byte_out", BYTE_OUT, m_out);
      chk("rnd_synced", SYNCED, !m_hunting);
      chk("rnd_frame_done", FRAME_DONE, m_done);
      chk("rnd_overrun", OVERRUN, m_ovr);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    BIT_VALID = 1'b0;
    repeat (gap - 1) tick();
    BIT_VALID = 1'b1;
    BIT_IN = b;
    tick();
    BIT_VALID = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic do_reset();
    BIT_VALID = 1'b0;
    BYTE_READY = 1'b0;
    OVR_CLR = 1'b0;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
  endtask

  int         sync_at;
  int         vld_at;
  logic [7:0] got;
  logic [7:0] b;
  bit         q[$];

  initial begin
    tbl[0] = '{pre: 8'h00, pre_len: 0, data: 8'hA3, exp_sync: 8,  exp_byte: 8'hA3};
    tbl[1] = '{pre: 8'h07, pre_len: 3, data: 8'h3C, exp_sync: 11, exp_byte: 8'h3C};
    tbl[2] = '{pre: 8'h00, pre_len: 2, data: 8'h00, exp_sync: 10, exp_byte: 8'h00};
    tbl[3] = '{pre: 8'h05, pre_len: 4, data: 8'hA3, exp_sync: 8,  exp_byte: 8'h35};
    tbl[4] = '{pre: 8'h00, pre_len: 1, data: 8'hFF, exp_sync: 9,  exp_byte: 8'hFF};

    #2;
    chk("rst_byte_out", BYTE_OUT, 0);
    chk("rst_byte_valid", BYTE_VALID, 0);
    chk("rst_synced", SYNCED, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    chk("rst_overrun", OVERRUN, 0);

    foreach (tbl[t]) begin
      do_reset();
      BYTE_READY = 1'b1;
      q.delete();
      for (int i = 0; i < tbl[t].pre_len; i++) q.push_back(tbl[t].pre[i]);
      for (int i = 0; i < 8; i++) q.push_back(sync_pat[i]);
      for (int i = 0; i < 8; i++) q.push_back(tbl[t].data[i]);
      sync_at = 0;
      vld_at = 0;
      got = '0;
      vld_seen = 0;
      for (int k = 0; k < q.size(); k++) begin
        send_bit(q[k], 1);
        if (SYNCED && sync_at == 0) sync_at = k + 1;
        if (BYTE_VALID && vld_at == 0) begin
          vld_at = k + 1;
          got = BYTE_OUT;
        end
      end
      tick();
      tick();
      chk($sformatf("tbl%0d_sync_bit", t), sync_at, tbl[t].exp_sync);
      chk($sformatf("tbl%0d_valid_bit", t), vld_at, tbl[t].exp_sync + 8);
      chk($sformatf("tbl%0d_byte", t), got, tbl[t].exp_byte);
      chk($sformatf("tbl%0d_valid_cycles", t), vld_seen, 1);
    end

    // Reset in the middle of a frame with a held byte and overrun pending.
    do_reset();
    send_byte(8'h55, 1);
    send_byte(8'hA3, 1);
    send_byte(8'h3C, 1);
    b = 8'h0F;
    for (int i = 0; i < 3; i++) send_bit(b[i], 1);
    chk("mid_pre_overrun", OVERRUN, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_rst_byte_out", BYTE_OUT, 0);
    chk("mid_rst_byte_valid", BYTE_VALID, 0);
    chk("mid_rst_synced", SYNCED, 0);
    chk("mid_rst_overrun", OVERRUN, 0);
    chk("mid_rst_frame_done", FRAME_DONE, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    sync_seen = 0;
    vld_seen = 0;
    send_byte(8'hA3, 1);
    send_byte(8'h3C, 1);
    chk("mid_data_no_sync", sync_seen, 0);
    chk("mid_data_no_valid", vld_seen, 0);

    // Backpressure, overrun clear, then accept coinciding with a new byte.
    do_reset();
    send_byte(8'h55, 1);
    chk("bp_synced", SYNCED, 1);
    send_byte(8'h11, 1);
    chk("bp_first_valid", BYTE_VALID, 1);
    chk("bp_first_out", BYTE_OUT, 8'h11);
    chk("bp_first_ovr", OVERRUN, 0);
    send_byte(8'h22, 1);
    chk("bp_held_out", BYTE_OUT, 8'h11);
    chk("bp_held_valid", BYTE_VALID, 1);
    chk("bp_overrun_set", OVERRUN, 1);
    OVR_CLR = 1'b1;
    tick();
    OVR_CLR = 1'b0;
    chk("bp_overrun_clr", OVERRUN, 0);
    BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    chk("bp_valid_drop", BYTE_VALID, 0);
    send_byte(8'h33, 1);
    chk("sim_third_out", BYTE_OUT, 8'h33);
    b = 8'h44;
    for (int i = 0; i < 7; i++) send_bit(b[i], 1);
    chk("sim_held_before", BYTE_OUT, 8'h33);
    BYTE_READY = 1'b1;
    send_bit(b[7], 1);
    chk("sim_valid_stays", BYTE_VALID, 1);
    chk("sim_out_update", BYTE_OUT, 8'h44);
    chk("sim_no_overrun", OVERRUN, 0);
    chk("sim_frame_done", FRAME_DONE, 1);
    chk("sim_unsynced", SYNCED, 0);
    tick();
    chk("sim_valid_after", BYTE_VALID, 0);
    chk("sim_done_pulse", FRAME_DONE, 0);
    BYTE_READY = 1'b0;

    // Frame end with bits every third cycle.
    do_reset();
    BYTE_READY = 1'b1;
    send_byte(8'h55, 3);
    chk("gap_synced", SYNCED, 1);
    for (int v = 1; v <= 4; v++) begin
      b = 8'(v);
      send_byte(b, 3);
      chk($sformatf("gap_byte%0d_out", v), BYTE_OUT, b);
      chk($sformatf("gap_byte%0d_valid", v), BYTE_VALID, 1);
      chk($sformatf("gap_byte%0d_done", v), FRAME_DONE, (v == 4) ? 1 : 0);
      chk($sformatf("gap_byte%0d_synced", v), SYNCED, (v == 4) ? 0 : 1);
    end
    tick();
    chk("gap_done_pulse", FRAME_DONE, 0);
    vld_seen = 0;
    send_byte(8'h05, 3);
    chk("gap_extra_no_valid", vld_seen, 0);
    chk("gap_extra_unsynced", SYNCED, 0);
    send_byte(8'h55, 3);
    chk("gap_resync", SYNCED, 1);
    chk("gap_resync_no_valid", vld_seen, 0);
    send_byte(8'h06, 3);
    chk("gap_next_frame_out", BYTE_OUT, 8'h06);
    chk("gap_next_frame_valid", BYTE_VALID, 1);

    // Random traffic with frequent sync bytes and misaligning bits.
    do_reset();
    q.delete();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) q.push_back(1'($urandom));
      end
      b = ($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
    end
    model_on = 1'b1;
    while (q.size() > 0) begin
      BIT_VALID = ($urandom_range(0, 3) != 0);
      if (BIT_VALID) BIT_IN = q.pop_front();
      BYTE_READY = ($urandom_range(0, 2) != 0);
      OVR_CLR = ($urandom_range(0, 15) == 0);
      tick();
    end
    model_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
